// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
//   Groups the loader's byte-stream handshake and its instruction-memory
//   write port.
//   master : loader view  (consumes the byte stream, drives the write port)
//   slave  : environment view (host byte source plus memory write sink)
//   Signals:
//     byte_valid / byte_data / byte_ready : valid/ready byte stream, MSB first
//     mem_we / mem_waddr / mem_wdata      : one-cycle word write strobe
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface imem_boot_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Boot-time sequencer for the instruction memory. Assembles big-endian
//   32-bit words from a byte stream, writes them to consecutive word
//   addresses starting at 0, and holds the core in reset until the load
//   completes.
//   Ports:
//     clk, rst    : clock (rising edge), asynchronous active-high reset
//     start_load  : pulse, begin loading load_len words
//     load_len    : word count, sampled with start_load (1..DEPTH valid)
//     abort       : cancel an in-progress load
//     bus         : byte stream in / memory write port out (master modport)
//     cpu_hold    : active-high hold to the core, low only after a load
//     busy        : load in progress
//     done        : last load completed, cleared by the next good start
//     err         : sticky bad-length/abort flag, cleared by a good start
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module imem_boot_loader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_load,
  input  logic [ADDR_W:0]     load_len,
  input  logic                abort,
  imem_boot_loader_if.master  bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  word, word_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [ADDR_W-1:0] word_cnt, word_cnt_n;
  logic [LEN_W-1:0]  len, len_n;
  logic              err_n, done_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [WIDTH-1:0]  wdata_n;
  logic              len_ok;
  logic              last_word;

  assign len_ok    = (load_len != '0) && (load_len <= LEN_W'(DEPTH));
  assign last_word = (({1'b0, word_cnt} + LEN_W'(1)) == len);

  always_comb begin
    state_n        = state;
    word_n         = word;
    byte_cnt_n     = byte_cnt;
    word_cnt_n     = word_cnt;
    len_n          = len;
    err_n          = err;
    done_n         = done;
    waddr_n        = bus.mem_waddr;
    wdata_n        = bus.mem_wdata;
    bus.byte_ready = 1'b0;

    case (state)
      IDLE, RUN: begin
        if (start_load) begin
          if (!len_ok) begin
            err_n = 1'b1;
          end else begin
            len_n      = load_len;
            err_n      = 1'b0;
            done_n     = 1'b0;
            word_cnt_n = '0;
            byte_cnt_n = '0;
            state_n    = LOAD;
          end
        end
      end

      LOAD: begin
        // Abort masks ready, so a simultaneous byte is never taken.
        bus.byte_ready = !abort;
        if (abort) begin
          err_n      = 1'b1;
          byte_cnt_n = '0;
          state_n    = IDLE;
        end else if (bus.byte_valid) begin
          word_n     = {word[WIDTH-9:0], bus.byte_data};
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            waddr_n = word_cnt;
            wdata_n = {word[WIDTH-9:0], bus.byte_data};
            state_n = WRITE;
          end
        end
      end

      WRITE: begin
        // The counter stops on the final word so a full-depth load
        // never wraps the address back to 0.
        if (last_word) begin
          done_n  = 1'b1;
          state_n = RUN;
        end else begin
          word_cnt_n = word_cnt + ADDR_W'(1);
          state_n    = LOAD;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      word          <= '0;
      byte_cnt      <= '0;
      word_cnt      <= '0;
      len           <= '0;
      err           <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      cpu_hold      <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state         <= state_n;
      word          <= word_n;
      byte_cnt      <= byte_cnt_n;
      word_cnt      <= word_cnt_n;
      len           <= len_n;
      err           <= err_n;
      done          <= done_n;
      busy          <= (state_n == LOAD) || (state_n == WRITE);
      cpu_hold      <= (state_n != RUN);
      bus.mem_we    <= (state_n == WRITE);
      bus.mem_waddr <= waddr_n;
      bus.mem_wdata <= wdata_n;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//   Randomised bench for imem_boot_loader. Expected memory writes are derived
//   from the byte stream (word i = bytes 4i..4i+3, big-endian, at address i)
//   and queued when a load is issued; an independent monitor pops and
//   compares on every mem_we.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_load;
  logic [ADDR_W:0] load_len;
  logic            abort;
  logic            cpu_hold, busy, done, err;

  imem_boot_loader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .load_len   (load_len),
    .abort      (abort),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  wr_t             sb[$];
  int unsigned     total  = 0;
  int unsigned     passed = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) begin
        last_addr = bus.mem_waddr;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write",
                   bus.mem_waddr, bus.mem_wdata);
        end else begin
          e = sb.pop_front();
          check("write_addr", 32'(bus.mem_waddr), 32'(e.addr));
          check("write_data", bus.mem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference model: the first nwords complete words of the stream.
  task automatic expect_words(input byte_q_t b, input int nwords);
    wr_t w;
    for (int i = 0; i < nwords; i++) begin
      w.addr = ADDR_W'(i);
      w.data = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
      sb.push_back(w);
    end
  endtask

  task automatic start(input int len);
    @(negedge clk);
    start_load = 1'b1;
    load_len   = 9'(len);
    @(negedge clk);
    start_load = 1'b0;
  endtask

  // Called just after a negedge; returns at the negedge following the handshake.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int unsigned guard = 0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    #1;
    while (bus.byte_ready !== 1'b1) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 100) begin
        total++;
        $display("FAIL byte_ready_timeout: got 0 expected 1");
        break;
      end
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic run_bytes(input byte_q_t b, input int max_gap, input int mid_start_at);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
      if (i == mid_start_at) begin
        start(1);
        check("busy_after_ignored_start", 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done", 32'(done), 32'd1);
  endtask

  task automatic full_load(input int len, input byte_q_t b, input int max_gap, input int mid);
    start(len);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_after_start", 32'(done), 32'd0);
    check("err_after_start", 32'(err), 32'd0);
    expect_words(b, len);
    run_bytes(b, max_gap, mid);
    wait_done();
    check("hold_in_run", 32'(cpu_hold), 32'd0);
    check("busy_in_run", 32'(busy), 32'd0);
    check("err_in_run", 32'(err), 32'd0);
    check("all_writes_seen", sb.size(), 32'd0);
  endtask

  function automatic byte_q_t words_to_bytes(input logic [31:0] w[$]);
    byte_q_t q;
    for (int i = 0; i < w.size(); i++)
      for (int k = 3; k >= 0; k--) q.push_back(w[i][8*k +: 8]);
    return q;
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    byte_q_t     b;
    logic [31:0] fact[$];

    rst = 1'b1; start_load = 1'b0; load_len = '0; abort = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;
    repeat (2) @(negedge clk);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_waddr", 32'(bus.mem_waddr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-word load, back-to-back bytes.
    b = '{8'h00, 8'h00, 8'h80, 8'h20, 8'h20, 8'h10, 8'h00, 8'h07};
    full_load(2, b, 0, -1);
    bus.byte_valid = 1'b1;
    #1;
    check("ready_in_run", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    bus.byte_valid = 1'b0;

    // Nine-word program, random gaps, ignored start_load while busy.
    fact = '{32'h00500513, 32'h00100293, 32'h00050863, 32'h02a282b3,
             32'hfff50513, 32'hff5ff06f, 32'h00502023, 32'h0000006f, 32'h00000013};
    b = words_to_bytes(fact);
    full_load(9, b, 3, 13);

    // Full-depth reload straight from RUN.
    b = rand_bytes(4 * DEPTH);
    full_load(DEPTH, b, 1, -1);
    check("last_addr", 32'(last_addr), 32'(DEPTH - 1));

    // Bad lengths from IDLE.
    rst = 1'b1; #2; rst = 1'b0;
    start(0);
    check("len0_err", 32'(err), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_hold", 32'(cpu_hold), 32'd1);
    bus.byte_valid = 1'b1;
    #1;
    check("ready_in_idle", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    start(DEPTH + 1);
    check("len257_err", 32'(err), 32'd1);
    check("len257_busy", 32'(busy), 32'd0);
    check("len257_hold", 32'(cpu_hold), 32'd1);
    b = rand_bytes(4);
    full_load(1, b, 2, -1);

    // Abort with a byte offered in the same cycle as the would-be 4th byte.
    b = rand_bytes(12);
    start(3);
    expect_words(b, 1);
    for (int i = 0; i < 7; i++) send_byte(b[i], int'($urandom_range(1, 0)));
    abort = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b[7];
    #1;
    check("ready_during_abort", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    bus.byte_valid = 1'b0;
    check("abort_err", 32'(err), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hold", 32'(cpu_hold), 32'd1);
    repeat (4) @(negedge clk);
    check("abort_no_extra", sb.size(), 32'd0);

    // Reset while the second word is being written.
    b = rand_bytes(16);
    start(4);
    expect_words(b, 2);
    for (int i = 0; i < 8; i++) send_byte(b[i], 0);
    check("we_before_rst", 32'(bus.mem_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_we", 32'(bus.mem_we), 32'd0);
    check("rst_mid_hold", 32'(cpu_hold), 32'd1);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_sb", sb.size(), 32'd0);
    b = rand_bytes(8);
    full_load(2, b, 2, -1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
